// File: rtl/noc_bridge_narrow_wide_pkg.sv
// Purpose: shared types and defaults for the narrow/wide network bridge.
//          Holds the channel-class encoding, default burst quotas and the
//          default starvation threshold used by the AXIS-out channel
//          scheduler, plus the scheduler state encoding.
package noc_bridge_narrow_wide_pkg;

   // Channel class index; also the bit position in per-class vectors.
   typedef enum logic [1:0] {
      ClsReq  = 2'd0,
      ClsRsp  = 2'd1,
      ClsWide = 2'd2
   } sched_class_e;

   // Default beats per grant for each class.
   localparam int unsigned DefaultQuotaReq  = 2;
   localparam int unsigned DefaultQuotaRsp  = 2;
   localparam int unsigned DefaultQuotaWide = 8;

   // Default number of waiting cycles before a class becomes urgent.
   localparam int unsigned StarveCyclesDefault = 16;

   // Scheduler state: free arbitration, or holding a multi-beat grant.
   typedef enum logic {
      SchedIdle   = 1'b0,
      SchedLocked = 1'b1
   } sched_state_e;

endpackage : noc_bridge_narrow_wide_pkg

// File: rtl/serial_link_sched_wait_cnt.sv
// Purpose: saturating wait counter for one channel class of the scheduler.
//          Counts cycles in which the class offers a beat that is not taken
//          and flags the class as starved once the count reaches the
//          threshold.
// Ports:
//   clk_i      clock
//   rst_ni     asynchronous active-low reset
//   valid_i    class has a beat pending
//   ready_i    class is being served this cycle (ready_o of that class)
//   starved_o  wait count has reached StarveCycles
module serial_link_sched_wait_cnt #(
   parameter int unsigned StarveCycles = 16,
   parameter int unsigned WaitWidth    = 6
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic valid_i,
   input  logic ready_i,
   output logic starved_o
);

   localparam logic [WaitWidth-1:0] WaitMax = '1;
   localparam logic [WaitWidth-1:0] Thresh  = WaitWidth'(StarveCycles);

   logic [WaitWidth-1:0] r_wait;

   // An idle class or a served beat restarts the count; otherwise the
   // count holds at its maximum instead of wrapping back to zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wait <= '0;
      end else if (!valid_i || ready_i) begin
         r_wait <= '0;
      end else if (r_wait != WaitMax) begin
         r_wait <= r_wait + 1'b1;
      end
   end

   assign starved_o = (r_wait >= Thresh);

endmodule : serial_link_sched_wait_cnt

// File: rtl/serial_link_floo_chan_sched.sv
// Purpose: weighted, starvation-safe scheduler sharing the AXIS-out
//          serializer path between the narrow request, narrow response and
//          wide channel classes. A granted class may send up to its quota
//          of consecutive beats; a class waiting StarveCycles becomes urgent
//          and cuts short any other class's burst after its next beat.
//          Zero latency: all outputs are combinational from the selection.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   cfg_quota_i     per-class max beats per grant (0 acts as 1)
//   valid_i/ready_o per-class input handshake (ready_o one-hot or zero)
//   data_i          per-class payload
//   valid_o/ready_i scheduled output handshake
//   data_o, idx_o   scheduled payload and its class
//   starved_o       per-class starvation status
module serial_link_floo_chan_sched
   import noc_bridge_narrow_wide_pkg::*;
#(
   parameter int unsigned NumChan      = 3,
   parameter int unsigned QuotaWidth   = 4,
   parameter int unsigned StarveCycles = StarveCyclesDefault,
   parameter int unsigned WaitWidth    = 6,
   parameter type         data_t       = logic,
   localparam int unsigned IdxW        = (NumChan > 1) ? $clog2(NumChan) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NumChan*QuotaWidth-1:0] cfg_quota_i,
   input  logic [NumChan-1:0]            valid_i,
   output logic [NumChan-1:0]            ready_o,
   input  data_t [NumChan-1:0]           data_i,
   output logic                          valid_o,
   input  logic                          ready_i,
   output data_t                         data_o,
   output logic [IdxW-1:0]               idx_o,
   output logic [NumChan-1:0]            starved_o
);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [QuotaWidth-1:0] quota_t;

   localparam logic [NumChan-1:0] OneHot0 = {{(NumChan-1){1'b0}}, 1'b1};

   sched_state_e     r_state, w_state_nxt;
   idx_t             r_rr_ptr, w_rr_ptr_nxt;
   idx_t             r_cur, w_cur_nxt;
   quota_t           r_burst_cnt, w_burst_cnt_nxt;

   logic [NumChan-1:0] w_starved;
   logic [NumChan-1:0] w_urgent;
   logic [NumChan-1:0] w_sel_oh;
   logic [NumChan-1:0] w_cur_oh;
   logic               w_locked_hit;
   logic               w_other_urgent;
   idx_t               w_rr_base;
   idx_t               w_idle_sel;
   idx_t               w_sel;
   quota_t             w_quota;
   logic               w_valid;
   logic               w_hs;

   function automatic idx_t next_idx(input idx_t i);
      return (32'(i) == NumChan - 1) ? idx_t'(0) : idx_t'(i + 1'b1);
   endfunction

   // First requester at or after ptr, wrapping (rotate + first-one search).
   function automatic idx_t rr_pick(input logic [NumChan-1:0] req, input idx_t ptr);
      idx_t        pick;
      logic        found;
      int unsigned c;
      pick  = ptr;
      found = 1'b0;
      for (int unsigned off = 0; off < NumChan; off++) begin
         c = (32'(ptr) + off) % NumChan;
         if (!found && req[c]) begin
            pick  = idx_t'(c);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   function automatic idx_t lowest_set(input logic [NumChan-1:0] req);
      idx_t pick;
      pick = '0;
      for (int c = NumChan - 1; c >= 0; c--) begin
         if (req[c]) pick = idx_t'(c);
      end
      return pick;
   endfunction

   function automatic quota_t quota_of(input idx_t c);
      quota_t q;
      q = cfg_quota_i[32'(c)*QuotaWidth +: QuotaWidth];
      return (q == '0) ? quota_t'(1) : q;
   endfunction

   for (genvar c = 0; c < NumChan; c++) begin : g_wait
      serial_link_sched_wait_cnt #(
         .StarveCycles (StarveCycles),
         .WaitWidth    (WaitWidth)
      ) u_wait_cnt (
         .clk_i     (clk_i),
         .rst_ni    (rst_ni),
         .valid_i   (valid_i[c]),
         .ready_i   (ready_o[c]),
         .starved_o (w_starved[c])
      );
   end

   // Selection. A locked class whose valid dropped releases in the same
   // cycle and arbitration restarts just after it, so no bubble appears.
   assign w_urgent     = w_starved & valid_i;
   assign w_locked_hit = (r_state == SchedLocked) && valid_i[r_cur];
   assign w_rr_base    = (r_state == SchedLocked) ? next_idx(r_cur) : r_rr_ptr;
   assign w_idle_sel   = (|w_urgent) ? lowest_set(w_urgent) : rr_pick(valid_i, w_rr_base);
   assign w_sel        = w_locked_hit ? r_cur : w_idle_sel;
   assign w_valid      = w_locked_hit | (|valid_i);
   assign w_hs         = w_valid & ready_i;
   assign w_quota      = quota_of(w_sel);
   assign w_sel_oh     = OneHot0 << w_sel;
   assign w_cur_oh     = OneHot0 << r_cur;
   // The burst owner's own urgency never cuts its burst short.
   assign w_other_urgent = |(w_urgent & ~w_cur_oh);

   // Outputs are forced quiet while reset is asserted, so an in-flight
   // beat is dropped immediately rather than at the next clock edge.
   assign valid_o   = w_valid & rst_ni;
   assign ready_o   = (rst_ni && w_valid && ready_i) ? w_sel_oh : '0;
   assign idx_o     = rst_ni ? w_sel : '0;
   assign data_o    = data_i[w_sel];
   assign starved_o = w_starved;

   always_comb begin
      w_state_nxt     = r_state;
      w_cur_nxt       = r_cur;
      w_burst_cnt_nxt = r_burst_cnt;
      w_rr_ptr_nxt    = r_rr_ptr;
      if (w_locked_hit) begin
         if (w_hs) begin
            // The beat completes first; release on quota end or urgency.
            if (r_burst_cnt == quota_t'(1) || w_other_urgent) begin
               w_state_nxt     = SchedIdle;
               w_burst_cnt_nxt = '0;
               w_rr_ptr_nxt    = next_idx(r_cur);
            end else begin
               w_burst_cnt_nxt = r_burst_cnt - 1'b1;
            end
         end
      end else begin
         w_state_nxt     = SchedIdle;
         w_burst_cnt_nxt = '0;
         w_rr_ptr_nxt    = w_rr_base;
         if (w_hs) begin
            // Quota is sampled here only; later cfg changes wait for the
            // next grant.
            if (w_quota == quota_t'(1)) begin
               w_rr_ptr_nxt = next_idx(w_sel);
            end else begin
               w_state_nxt     = SchedLocked;
               w_cur_nxt       = w_sel;
               w_burst_cnt_nxt = w_quota - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= SchedIdle;
         r_rr_ptr    <= '0;
         r_cur       <= '0;
         r_burst_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_rr_ptr    <= w_rr_ptr_nxt;
         r_cur       <= w_cur_nxt;
         r_burst_cnt <= w_burst_cnt_nxt;
      end
   end

endmodule : serial_link_floo_chan_sched
